// File: rtl/rr_req_arbiter.sv
// rr_req_arbiter
// Round-robin arbiter feeding the 4-to-2 one-hot encoder stage. A grant is
// held by its owner until the owner pulses done or withdraws its request;
// the priority pointer then advances past the owner and re-arbitration
// happens on the same edge, so there are no dead cycles between owners.
//
// Ports:
//   clk      in   rising-edge system clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [IN-1:0] request lines, bit i = requester i wants the resource
//   done     in   owner release pulse, looked at only while busy
//   gnt      out  [IN-1:0] registered one-hot grant, zero when idle
//   gnt_idx  out  [$clog2(IN)-1:0] binary index of the owner, zero when idle
//   busy     out  high while a grant is active (equals |gnt)
module rr_req_arbiter #(
  parameter int IN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN-1:0]         req,
  input  logic                  done,
  output logic [IN-1:0]         gnt,
  output logic [$clog2(IN)-1:0] gnt_idx,
  output logic                  busy
);

  localparam int W = $clog2(IN);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    ptr;
  logic [W-1:0]    ptr_nxt;
  logic [IN-1:0]   gnt_nxt;
  logic [W-1:0]    idx_nxt;
  logic            busy_nxt;
  logic [W:0]      pick_res;

  // Index after i, wrapping at IN so the pointer never reaches IN or above.
  function automatic logic [W-1:0] next_idx(input logic [W-1:0] i);
    logic [W-1:0] n;
    if (i == W'(IN - 1)) begin
      n = {W{1'b0}};
    end else begin
      n = i + {{(W-1){1'b0}}, 1'b1};
    end
    return n;
  endfunction

  // First set request scanning base, base+1, ... cyclically.
  // Returns {found, index}.
  function automatic logic [W:0] pick(input logic [IN-1:0] r,
                                      input logic [W-1:0]  base);
    logic         found;
    logic [W-1:0] sel;
    logic [W-1:0] cand;
    logic [W:0]   pos;
    found = 1'b0;
    sel   = {W{1'b0}};
    for (int k = 0; k < IN; k++) begin
      pos = {1'b0, base} + (W+1)'(k);
      if (pos >= (W+1)'(IN)) begin
        pos = pos - (W+1)'(IN);
      end else begin
        pos = pos;
      end
      cand = pos[W-1:0];
      if (!found && r[cand]) begin
        found = 1'b1;
        sel   = cand;
      end else begin
        found = found;
      end
    end
    return {found, sel};
  endfunction

  // Next-state and next-output decode for the IDLE/GRANT controller.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    idx_nxt   = gnt_idx;
    busy_nxt  = busy;
    pick_res  = {(W+1){1'b0}};
    case (state)
      IDLE: begin
        pick_res = pick(req, ptr);
      end
      GRANT: begin
        if (done || !req[gnt_idx]) begin
          // Release: the owner drops to lowest priority for this arbitration.
          ptr_nxt  = next_idx(gnt_idx);
          pick_res = pick(req, next_idx(gnt_idx));
        end else begin
          pick_res = {(W+1){1'b0}};
        end
      end
      default: begin
        pick_res = {(W+1){1'b0}};
      end
    endcase

    // Apply the arbitration result only when one was actually evaluated.
    if (state == GRANT && !(done || !req[gnt_idx])) begin
      state_nxt = GRANT;
    end else if (pick_res[W]) begin
      state_nxt = GRANT;
      gnt_nxt   = {{(IN-1){1'b0}}, 1'b1} << pick_res[W-1:0];
      idx_nxt   = pick_res[W-1:0];
      busy_nxt  = 1'b1;
    end else begin
      state_nxt = IDLE;
      gnt_nxt   = {IN{1'b0}};
      idx_nxt   = {W{1'b0}};
      busy_nxt  = 1'b0;
    end
  end

  // State, pointer and registered outputs; reset clears them immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= {W{1'b0}};
      gnt     <= {IN{1'b0}};
      gnt_idx <= {W{1'b0}};
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt     <= gnt_nxt;
      gnt_idx <= idx_nxt;
      busy    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Testbench for rr_req_arbiter: directed scenarios followed by random
// traffic. Stimulus is applied on the falling edge; the expected post-edge
// outputs from a reference model are queued and a separate monitor compares
// them one cycle-edge later.
module tb_rr_req_arbiter;

  localparam int IN = 4;
  localparam int W  = $clog2(IN);

  logic          clk;
  logic          rst_n;
  logic [IN-1:0] req;
  logic          done;
  logic [IN-1:0] gnt;
  logic [W-1:0]  gnt_idx;
  logic          busy;

  rr_req_arbiter #(.IN(IN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IN-1:0] g;
    logic [W-1:0]  i;
    logic          b;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model: who owns the resource (-1 = nobody) and whose turn is next.
  int m_owner = -1;
  int m_ptr   = 0;

  // Requesters listed in priority order starting at p; first one asking wins.
  function automatic int first_requester(input logic [IN-1:0] r, input int p);
    int order[$];
    for (int k = 0; k < IN; k++) order.push_back((p + k) % IN);
    foreach (order[j]) if (r[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic model_step(input logic [IN-1:0] r, input logic d);
    if (m_owner < 0) begin
      if (r != '0) m_owner = first_requester(r, m_ptr);
    end else if (d || !r[m_owner]) begin
      m_ptr   = (m_owner + 1) % IN;
      m_owner = first_requester(r, m_ptr);
    end
  endtask

  task automatic check(input string name, input logic [IN-1:0] ag, input logic [W-1:0] ai,
                       input logic ab, input logic [IN-1:0] eg, input logic [W-1:0] ei,
                       input logic eb, input int c);
    tests++;
    if (ag !== eg || ai !== ei || ab !== eb) begin
      fails++;
      $display("FAIL %s cycle=%0d got gnt=%b idx=%0d busy=%b expected gnt=%b idx=%0d busy=%b",
               name, c, ag, ai, ab, eg, ei, eb);
    end
  endtask

  // One clock of stimulus: drive on the falling edge, queue the expectation.
  task automatic cycle(input logic [IN-1:0] r, input logic d, input logic rst);
    exp_t e;
    logic was_up;
    @(negedge clk);
    was_up = rst_n;
    req    = r;
    done   = d;
    rst_n  = rst;
    cyc++;
    if (!rst) begin
      m_owner = -1;
      m_ptr   = 0;
      if (was_up) begin
        // Reset must clear the outputs without waiting for a clock edge.
        #1;
        check("async_reset", gnt, gnt_idx, busy, '0, '0, 1'b0, cyc);
      end
    end else begin
      model_step(r, d);
    end
    e.g   = (m_owner >= 0) ? IN'(1) << m_owner : '0;
    e.i   = (m_owner >= 0) ? W'(m_owner) : '0;
    e.b   = (m_owner >= 0);
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Monitor: after every rising edge, compare outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant", gnt, gnt_idx, busy, e.g, e.i, e.b, e.cyc);
        tests++;
        if (!$onehot0(gnt) || (busy !== |gnt) || (busy && !gnt[gnt_idx])) begin
          fails++;
          $display("FAIL invariant cycle=%0d got gnt=%b idx=%0d busy=%b required one-hot-or-zero, busy==|gnt, gnt[idx]",
                   e.cyc, gnt, gnt_idx, busy);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin
    req   = '0;
    done  = 1'b0;
    rst_n = 1'b0;

    // Reset for two cycles, then idle with no requests.
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    repeat (3) cycle(4'b0000, 1'b0, 1'b1);

    // Single requester: grant, hold, release with done.
    cycle(4'b0010, 1'b0, 1'b1);
    repeat (3) cycle(4'b0010, 1'b0, 1'b1);
    cycle(4'b0000, 1'b1, 1'b1);

    // Rotation from ptr=0 with everyone requesting and done every grant cycle.
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b1);
    repeat (4) cycle(4'b1111, 1'b1, 1'b1);
    cycle(4'b0000, 1'b1, 1'b1);

    // Wrap and skip: owner 2 releases, ptr=3, only 0 and 1 request.
    cycle(4'b0100, 1'b0, 1'b1);
    cycle(4'b0011, 1'b1, 1'b1);
    cycle(4'b0011, 1'b1, 1'b1);

    // Owner 1 withdraws without done; then done in IDLE is ignored.
    cycle(4'b0001, 1'b0, 1'b1);
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0000, 1'b1, 1'b1);

    // Async reset while requester 2 holds the grant.
    cycle(4'b0100, 1'b0, 1'b1);
    cycle(4'b0100, 1'b0, 1'b1);
    cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b1);
    cycle(4'b1111, 1'b1, 1'b1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      cycle(IN'($urandom_range(0, (1 << IN) - 1)),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 99) != 0));
    end

    // Let the monitor drain the queue.
    for (int n = 0; n < 5 && exp_q.size() > 0; n++) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_req_arbiter.md
Name: rr_req_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 4-to-2 one-hot encoder stage.
- Accepts up to IN request lines and produces a registered one-hot grant vector. The one-hot vector feeds the encoder input directly.
- Also produces a matching binary grant index for consumers that bypass the encoder.
- Grants are held until released by the owner, then rotate fairly.

Parameters:
- IN, 4, number of requesters. Must be ≥2. gnt width = IN; gnt_idx width = $clog2(IN).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  IN  request lines; bit i high = requester i wants the resource.
- done  input  1  owner release pulse; sampled only while busy=1.
- gnt  output  IN  registered one-hot grant; all-zero when idle. Feeds encoder a[IN-1:0].
- gnt_idx  output  $clog2(IN)  binary index of the current owner; 0 when idle.
- busy  output  1  high while a grant is active; equals |gnt.

Behaviour:
- Reset (rst_n=0, async, any time including mid-grant): gnt=0, gnt_idx=0, busy=0, internal priority pointer ptr=0, state=IDLE. Outputs clear immediately, not at the next edge.
- Internal state: 2-state FSM (IDLE, GRANT) plus ptr[$clog2(IN)-1:0].
  - ptr = highest-priority requester for the next arbitration.
  - Priority order: ptr, ptr+1, ..., IN-1, 0, ..., ptr-1 (cyclic wrap mod IN).
- IDLE:
  - If req != 0 at a rising edge: at that edge, select the first set bit in the ptr-rotated order.
  - Register gnt = one-hot(sel), gnt_idx = sel, busy = 1, go to GRANT.
  - Latency: 1 clock from req sampled to gnt visible.
  - If req == 0: remain in IDLE, outputs stay 0. done is ignored in IDLE.
- GRANT:
  - gnt/gnt_idx hold stable while req[gnt_idx]=1 and done=0. Changes on other req bits have no effect.
  - A release event is done=1, or req[gnt_idx]=0 (owner withdrew).
  - On a release edge, ptr <= (gnt_idx+1) mod IN.
  - Back-to-back re-arbitration happens in the same edge, using the new ptr value and the current req.
  - When evaluating that re-arbitration, the releasing owner's req bit is considered only if done=0 is false. In other words, if done=1 and the owner still requests, it sits at lowest priority, because the new ptr already excludes it first.
  - If any eligible request exists: new one-hot grant, stay in GRANT, busy stays 1. There are no dead cycles.
  - Else: gnt=0, gnt_idx=0, busy=0, go to IDLE.
- Invariants, checked every cycle:
  - gnt is zero or exactly one-hot.
  - gnt[gnt_idx]=1 whenever busy=1.
  - busy == |gnt.
  - Grants never go to a requester whose req bit was 0 at the granting edge.
- Fairness: with all IN requesters continuously asserting, each is granted exactly once in any IN consecutive grants.
- Wrap-around: ptr increments modulo IN. When IN is not a power of two, ptr never takes values ≥IN.
- Outputs are fully registered; there is no combinational path from req/done to gnt.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, release, req=0000 → gnt=0000, gnt_idx=00, busy=0 for all following cycles.
- Single requester:
  - req=0010 at edge N → gnt=0010, gnt_idx=01, busy=1 at N+1.
  - Hold 3 cycles with done=0 → unchanged.
  - done=1 at edge N+4 with req=0000 → gnt=0000, busy=0 at N+5.
- Rotation:
  - req=1111 held, done=1 every cycle in GRANT → gnt sequence 0001, 0010, 0100, 1000, 0001.
  - gnt_idx sequence 0, 1, 2, 3, 0.
  - busy stays high with no gaps.
- Wrap and skip:
  - After owner 2 releases (ptr=3), req=0011 → next gnt=0001 (idx 0).
  - Then release → gnt=0010 (idx 1).
- Withdrawal and ignored done:
  - Owner 1 drops req[1] without done → released on that edge, ptr=2.
  - With req=0001 → gnt=0001 on the same edge.
  - done=1 in IDLE with req=0000 → no output change.
- Async reset mid-grant: gnt=0100 active, pulse rst_n low between clock edges → gnt=0000, busy=0 immediately; after release with req=1111 → first grant is 0001 (ptr reset to 0).
